// File: rtl/mem_load_ctrl_pkg.sv
// Shared load op codes, engine state type and address-check helpers for the MEM-stage load path.
package mem_load_ctrl_pkg;

   localparam int LD_OP_W = 8;

   localparam logic [LD_OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [LD_OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [LD_OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [LD_OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [LD_OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } ld_state_e;

   function automatic logic is_load(input logic [LD_OP_W-1:0] op);
      return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
             (op == EXE_LHU_OP) || (op == EXE_LW_OP);
   endfunction

   function automatic logic is_misaligned(input logic [LD_OP_W-1:0] op, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      if (op == EXE_LH_OP || op == EXE_LHU_OP) mis = off[0];
      else if (op == EXE_LW_OP)                mis = (off != 2'b00);
      return mis;
   endfunction

endpackage

// File: rtl/mem_load_ctrl_load_extend.sv
// Combinational lane select and sign/zero extension of a little-endian read word.
// Shared by the load engine and the forwarding path.
module load_extend
   import mem_load_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [LD_OP_W-1:0] op_i,
   input  logic [1:0]         off_i,
   input  logic [DATA_W-1:0]  rdata_i,
   output logic [DATA_W-1:0]  result_o
);

   logic [DATA_W-1:0] byte_shift;
   logic [DATA_W-1:0] half_shift;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;

   always_comb begin
      byte_shift = rdata_i >> {off_i, 3'b000};
      half_shift = rdata_i >> {off_i[1], 4'b0000};
      lane_b     = byte_shift[7:0];
      lane_h     = half_shift[15:0];
      case (op_i)
         EXE_LB_OP:  result_o = {{(DATA_W-8){lane_b[7]}}, lane_b};
         EXE_LBU_OP: result_o = {{(DATA_W-8){1'b0}}, lane_b};
         EXE_LH_OP:  result_o = {{(DATA_W-16){lane_h[15]}}, lane_h};
         EXE_LHU_OP: result_o = {{(DATA_W-16){1'b0}}, lane_h};
         default:    result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_load_ctrl.sv
// MEM-stage load engine: alignment check, word read over the req/addr_ok/data_ok bus,
// lane extraction, pipeline stall while the read is outstanding.
module mem_load_ctrl
   import mem_load_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int OP_W   = LD_OP_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ld_valid_i,
   input  logic [OP_W-1:0]   ld_op_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   output logic              ld_ready_o,
   input  logic              flush_i,
   output logic              stall_o,
   output logic              data_req_o,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic [1:0]        data_size_o,
   input  logic              data_addr_ok_i,
   input  logic              data_data_ok_i,
   input  logic [DATA_W-1:0] data_rdata_i,
   output logic              ld_done_o,
   output logic [DATA_W-1:0] ld_rdata_o,
   output logic              adel_o,
   output logic [ADDR_W-1:0] badvaddr_o
);

   ld_state_e         state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              killed_q, killed_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              adel_q, adel_d;
   logic [ADDR_W-1:0] badvaddr_q, badvaddr_d;
   logic [DATA_W-1:0] ext_rdata;
   logic              capture;

   load_extend #(.DATA_W(DATA_W)) u_extend (
      .op_i     (op_q),
      .off_i    (addr_q[1:0]),
      .rdata_i  (data_rdata_i),
      .result_o (ext_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         op_q       <= '0;
         addr_q     <= '0;
         killed_q   <= 1'b0;
         rdata_q    <= '0;
         adel_q     <= 1'b0;
         badvaddr_q <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         killed_q   <= killed_d;
         rdata_q    <= rdata_d;
         adel_q     <= adel_d;
         badvaddr_q <= badvaddr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      killed_d   = killed_q;
      rdata_d    = rdata_q;
      adel_d     = 1'b0;
      badvaddr_d = badvaddr_q;
      capture    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ld_valid_i && !flush_i && is_load(ld_op_i)) begin
               if (is_misaligned(ld_op_i, ld_addr_i[1:0])) begin
                  adel_d     = 1'b1;
                  badvaddr_d = ld_addr_i;
               end else begin
                  op_d    = ld_op_i;
                  addr_d  = ld_addr_i;
                  state_d = ST_REQ;
               end
            end
         end
         // A flushed request stays on the bus until accepted so the slave sees a clean handshake.
         ST_REQ: begin
            killed_d = killed_q | flush_i;
            if (data_addr_ok_i) begin
               if (data_data_ok_i) begin
                  capture = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            killed_d = killed_q | flush_i;
            if (data_data_ok_i) begin
               capture = 1'b1;
               state_d = ST_DONE;
            end
         end
         default: begin
            killed_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
      if (capture && !killed_d) rdata_d = ext_rdata;
   end

   assign ld_ready_o  = (state_q == ST_IDLE);
   assign data_req_o  = (state_q == ST_REQ);
   assign stall_o     = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                        ((state_q == ST_DONE) && killed_q);
   assign data_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
   assign data_size_o = 2'b10;
   assign ld_done_o   = (state_q == ST_DONE) && !killed_q && !flush_i;
   assign ld_rdata_o  = rdata_q;
   assign adel_o      = adel_q;
   assign badvaddr_o  = badvaddr_q;

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Scoreboard bench for mem_load_ctrl: directed load cases plus randomized loads against a value model.
module tb_mem_load_ctrl;
   import mem_load_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_valid = 1'b0;
   logic [7:0]  ld_op = 8'h00;
   logic [31:0] ld_addr = 32'h0;
   logic        flush = 1'b0;
   logic        data_addr_ok = 1'b0;
   logic        data_data_ok = 1'b0;
   logic [31:0] data_rdata = 32'h0;
   logic        ld_ready, stall, data_req, ld_done, adel;
   logic [31:0] data_addr, ld_rdata, badvaddr;
   logic [1:0]  data_size;

   mem_load_ctrl dut (
      .clk_i(clk), .rst_i(rst), .ld_valid_i(ld_valid), .ld_op_i(ld_op), .ld_addr_i(ld_addr),
      .ld_ready_o(ld_ready), .flush_i(flush), .stall_o(stall), .data_req_o(data_req),
      .data_addr_o(data_addr), .data_size_o(data_size), .data_addr_ok_i(data_addr_ok),
      .data_data_ok_i(data_data_ok), .data_rdata_i(data_rdata), .ld_done_o(ld_done),
      .ld_rdata_o(ld_rdata), .adel_o(adel), .badvaddr_o(badvaddr)
   );

   always #5 clk = ~clk;

   typedef struct { bit is_adel; logic [31:0] val; } exp_t;
   exp_t        exp_q[$];
   logic [31:0] mem[logic [31:0]];
   logic [31:0] last_rdata = 32'h0;
   int          rsp_addr_dly = 0;
   int          rsp_data_dly = 1;
   int          checks = 0;
   int          failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      logic [31:0] w;
      w = a & 32'hFFFF_FFFC;
      if (!mem.exists(w)) mem[w] = $urandom;
      return mem[w];
   endfunction

   // Reference: little-endian lane pick with plain arithmetic, extension by value range.
   function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] a);
      logic [31:0] word, v;
      word = mem_rd(a);
      v = word;
      if (op == EXE_LB_OP || op == EXE_LBU_OP) begin
         v = (word / (32'd1 << (8 * (a % 4)))) % 256;
         if (op == EXE_LB_OP && v >= 128) v = v - 256;
      end else if (op == EXE_LH_OP || op == EXE_LHU_OP) begin
         v = (word / (32'd1 << (16 * ((a % 4) / 2)))) % 65536;
         if (op == EXE_LH_OP && v >= 32768) v = v - 65536;
      end
      return v;
   endfunction

   function automatic bit ref_is_load(input logic [7:0] op);
      return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP ||
             op == EXE_LHU_OP || op == EXE_LW_OP;
   endfunction

   function automatic bit ref_misaligned(input logic [7:0] op, input logic [31:0] a);
      if (op == EXE_LW_OP) return (a % 4) != 0;
      if (op == EXE_LH_OP || op == EXE_LHU_OP) return (a % 2) != 0;
      return 1'b0;
   endfunction

   // Monitor: every ld_done/adel pulse must match the oldest expectation.
   initial forever begin
      @(negedge clk); #1;
      if (!rst) begin
         if (ld_done) begin
            if (exp_q.size() == 0 || exp_q[0].is_adel) begin
               checks++; failures++;
               $display("FAIL unexpected_done actual=ld_done rdata=0x%08h required=no pulse", ld_rdata);
            end else begin
               chk("ld_rdata", ld_rdata, exp_q[0].val);
               void'(exp_q.pop_front());
            end
         end
         if (adel) begin
            if (exp_q.size() == 0 || !exp_q[0].is_adel) begin
               checks++; failures++;
               $display("FAIL unexpected_adel actual=adel badvaddr=0x%08h required=no pulse", badvaddr);
            end else begin
               chk("badvaddr", badvaddr, exp_q[0].val);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // Bus slave: accepts after rsp_addr_dly cycles, returns data rsp_data_dly cycles after accept.
   initial forever begin
      logic [31:0] a;
      int ad, dd;
      bit live;
      @(negedge clk);
      if (data_req && !rst) begin
         a = data_addr; ad = rsp_addr_dly; dd = rsp_data_dly; live = 1'b1;
         for (int i = 0; i < ad; i++) begin
            @(negedge clk);
            if (!data_req) begin
               live = 1'b0;
               break;
            end
            chk("addr_stable", data_addr, a);
            chk("stall_in_req", {31'd0, stall}, 32'd1);
         end
         if (live) begin
            data_addr_ok = 1'b1;
            if (dd == 0) begin
               data_data_ok = 1'b1;
               data_rdata = mem_rd(a);
            end
            @(negedge clk);
            data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
            if (dd > 0) begin
               repeat (dd - 1) @(negedge clk);
               data_data_ok = 1'b1; data_rdata = mem_rd(a);
               @(negedge clk);
               data_data_ok = 1'b0; data_rdata = $urandom;
            end
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!ld_ready && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      if (!ld_ready) chk("ready_timeout", {31'd0, ld_ready}, 32'd1);
   endtask

   // fk: negedge index (after presenting the load) at which flush pulses; -1 = none.
   task automatic do_load(input logic [7:0] op, input logic [31:0] a, input int ad, input int dd,
                          input int fk);
      int  lat;
      bit  ign, mis, killed, stall_ok;
      exp_t e;
      wait_ready();
      @(negedge clk);
      lat = 2 + ad + dd;
      ign = !ref_is_load(op) || fk == 0;
      mis = ref_misaligned(op, a);
      killed = fk >= 1 && fk < lat;
      rsp_addr_dly = ad; rsp_data_dly = dd;
      if (!ign && mis) begin
         e.is_adel = 1'b1; e.val = a; exp_q.push_back(e);
      end else if (!ign) begin
         e.is_adel = 1'b0; e.val = ref_load(op, a);
         if (fk < 0) exp_q.push_back(e);
         if (!killed) last_rdata = e.val;
      end
      ld_valid = 1'b1; ld_op = op; ld_addr = a; flush = (fk == 0);
      stall_ok = 1'b1;
      for (int k = 1; k <= ((ign || mis) ? 3 : lat + 1); k++) begin
         @(negedge clk);
         ld_valid = 1'b0;
         flush = (k == fk);
         #1;
         if (ign || mis) begin
            if (k == 3) chk("no_bus_req", {31'd0, data_req}, 32'd0);
         end else begin
            if (k == 1) begin
               chk("req_issued", {31'd0, data_req}, 32'd1);
               chk("data_addr", data_addr, a & 32'hFFFF_FFFC);
               chk("data_size", {30'd0, data_size}, 32'd2);
            end
            if (k < lat && !stall) stall_ok = 1'b0;
            if (k == lat) begin
               chk("done_latency", {31'd0, ld_done}, (fk < 0) ? 32'd1 : 32'd0);
               chk("stall_in_done", {31'd0, stall}, {31'd0, killed});
            end
            if (k == lat + 1) begin
               chk("ready_after_done", {31'd0, ld_ready}, 32'd1);
               if (killed) chk("killed_rdata_held", ld_rdata, last_rdata);
            end
         end
      end
      if (!ign && !mis) chk("stall_busy", {31'd0, stall_ok}, 32'd1);
      flush = 1'b0;
   endtask

   initial begin
      logic [7:0] ops[6];
      logic [31:0] a;
      int ad, dd, fk;
      ops[0] = EXE_LB_OP; ops[1] = EXE_LBU_OP; ops[2] = EXE_LH_OP;
      ops[3] = EXE_LHU_OP; ops[4] = EXE_LW_OP; ops[5] = 8'h20;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready", {31'd0, ld_ready}, 32'd1);
      chk("rst_req", {31'd0, data_req}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_done_adel", {30'd0, ld_done, adel}, 32'd0);
      chk("rst_rdata", ld_rdata, 32'd0);
      chk("rst_badvaddr", badvaddr, 32'd0);

      mem[32'h1000] = 32'h8011_2233;
      mem[32'h2000] = 32'hBEEF_1234;
      do_load(EXE_LB_OP,  32'h1003, 0, 1, -1);
      do_load(EXE_LBU_OP, 32'h1003, 0, 1, -1);
      do_load(EXE_LH_OP,  32'h2002, 0, 1, -1);
      do_load(EXE_LHU_OP, 32'h2000, 0, 1, -1);
      do_load(EXE_LW_OP,  32'h2000, 0, 1, -1);
      do_load(EXE_LW_OP,  32'h3001, 0, 1, -1);
      do_load(EXE_LH_OP,  32'h3003, 0, 1, -1);
      do_load(EXE_LW_OP,  32'h2000, 3, 2, -1);
      do_load(EXE_LBU_OP, 32'h1001, 0, 0, -1);
      do_load(EXE_LW_OP,  32'h1000, 0, 3, 2);
      do_load(8'h20,      32'h1000, 0, 1, -1);

      // Stray data beat while idle must not complete anything.
      @(negedge clk);
      data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      data_data_ok = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("idle_beat_rdata", ld_rdata, last_rdata);

      // Reset while the request is outstanding.
      wait_ready();
      @(negedge clk);
      rsp_addr_dly = 20;
      ld_valid = 1'b1; ld_op = EXE_LW_OP; ld_addr = 32'h4000;
      @(negedge clk);
      ld_valid = 1'b0;
      #1;
      chk("rst_test_req", {31'd0, data_req}, 32'd1);
      @(negedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_req", {31'd0, data_req}, 32'd0);
      chk("async_rst_stall", {31'd0, stall}, 32'd0);
      chk("async_rst_rdata", ld_rdata, 32'd0);
      last_rdata = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      do_load(EXE_LH_OP, 32'h2002, 0, 1, -1);

      for (int n = 0; n < 60; n++) begin
         a  = 32'h5000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
         ad = $urandom_range(0, 3);
         dd = $urandom_range(0, 3);
         fk = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2 + ad + dd) : -1;
         do_load(ops[$urandom_range(0, 5)], a, ad, dd, fk);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
